// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flushes,
// data-memory wait freeze with sticky timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_use,
    input  logic             i_id_rs2_use,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_is_load,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_pc_sel,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_en,
    output logic             o_stall_if_id,
    output logic             o_flush_if_id,
    output logic             o_stall_id_ex,
    output logic             o_flush_id_ex,
    output logic             o_stall_ex_mem,
    output logic             o_flush_mem_wb,
    output logic             o_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam int            WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic mem_wait_now;
    logic freeze;
    logic redirect;
    logic lu_match;
    logic load_use;
    logic stall_any;

    always_comb begin
        mem_wait_now = i_mem_req & ~i_mem_ack;
        freeze       = mem_wait_now | (state_q == ST_ERR);
        lu_match     = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
                       ((i_id_rs1_use & (i_id_rs1_addr == i_ex_rd_addr)) |
                        (i_id_rs2_use & (i_id_rs2_addr == i_ex_rd_addr)));
        // A redirect makes the ID instruction wrong-path, so it masks load-use.
        redirect     = ~freeze & i_ex_pc_sel;
        load_use     = ~freeze & ~i_ex_pc_sel & lu_match;
        stall_any    = freeze | load_use;

        o_pc_en        = ~(freeze | load_use);
        o_stall_if_id  = freeze | load_use;
        o_flush_if_id  = redirect;
        o_stall_id_ex  = freeze;
        o_flush_id_ex  = redirect | load_use;
        o_stall_ex_mem = freeze;
        o_flush_mem_wb = freeze;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = err_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                // The timeout check also applies in RUN so MEM_TIMEOUT=1 errors on the first miss.
                if (mem_wait_now) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_any && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_err       = err_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl: two instances (default and
// MEM_TIMEOUT=4/CNT_W=4) share stimulus and are checked every cycle against a rule model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, wr, pcs, req, ack;

    logic       a_pc_en, a_st_ifid, a_fl_ifid, a_st_idex, a_fl_idex, a_st_exmem, a_fl_memwb, a_err;
    logic       b_pc_en, b_st_ifid, b_fl_ifid, b_st_idex, b_fl_idex, b_st_exmem, b_fl_memwb, b_err;
    logic [31:0] a_scnt, a_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    pipe_hazard_ctrl u_a (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_use(u1), .i_id_rs2_use(u2),
        .i_ex_rd_addr(rd), .i_ex_is_load(ld), .i_ex_rd_wren(wr), .i_ex_pc_sel(pcs),
        .i_mem_req(req), .i_mem_ack(ack),
        .o_pc_en(a_pc_en), .o_stall_if_id(a_st_ifid), .o_flush_if_id(a_fl_ifid),
        .o_stall_id_ex(a_st_idex), .o_flush_id_ex(a_fl_idex), .o_stall_ex_mem(a_st_exmem),
        .o_flush_mem_wb(a_fl_memwb), .o_err(a_err), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_b (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_use(u1), .i_id_rs2_use(u2),
        .i_ex_rd_addr(rd), .i_ex_is_load(ld), .i_ex_rd_wren(wr), .i_ex_pc_sel(pcs),
        .i_mem_req(req), .i_mem_ack(ack),
        .o_pc_en(b_pc_en), .o_stall_if_id(b_st_ifid), .o_flush_if_id(b_fl_ifid),
        .o_stall_id_ex(b_st_idex), .o_flush_id_ex(b_fl_idex), .o_stall_ex_mem(b_st_exmem),
        .o_flush_mem_wb(b_fl_memwb), .o_err(b_err), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Model state: sticky error, consecutive unacked cycles, counters.
    bit     m_valid = 1'b0;
    bit     m_err[2];
    int     m_consec[2];
    longint m_scnt[2];
    longint m_fcnt[2];
    int     m_to[2]  = '{255, 4};
    longint m_max[2] = '{64'd4294967295, 64'd15};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic compare();
        string      nm[8] = '{"pc_en", "stall_if_id", "flush_if_id", "stall_id_ex",
                              "flush_id_ex", "stall_ex_mem", "flush_mem_wb", "err"};
        logic [7:0] act[2];
        logic [63:0] acs[2], acf[2];
        logic [7:0] exp;
        bit hz, frz, red, lu;
        act[0] = {a_pc_en, a_st_ifid, a_fl_ifid, a_st_idex, a_fl_idex, a_st_exmem, a_fl_memwb, a_err};
        act[1] = {b_pc_en, b_st_ifid, b_fl_ifid, b_st_idex, b_fl_idex, b_st_exmem, b_fl_memwb, b_err};
        acs[0] = {32'd0, a_scnt}; acf[0] = {32'd0, a_fcnt};
        acs[1] = {60'd0, b_scnt}; acf[1] = {60'd0, b_fcnt};
        hz = ld && wr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 2; k++) begin
            frz = m_err[k] || (req && !ack);
            red = !frz && pcs;
            lu  = !frz && !pcs && hz;
            exp = {!(frz || lu), frz || lu, red, frz, red || lu, frz, frz, m_err[k]};
            if (m_valid) begin
                for (int s = 0; s < 8; s++) begin
                    chk($sformatf("%s_%s", k == 0 ? "a" : "b", nm[s]), {63'd0, act[k][7-s]}, {63'd0, exp[7-s]});
                end
                chk(k == 0 ? "a_stall_cnt" : "b_stall_cnt", acs[k], m_scnt[k]);
                chk(k == 0 ? "a_flush_cnt" : "b_flush_cnt", acf[k], m_fcnt[k]);
            end
            if (rst) begin
                m_err[k] = 0; m_consec[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
            end else begin
                if (frz || lu) m_scnt[k] = (m_scnt[k] >= m_max[k]) ? m_max[k] : m_scnt[k] + 1;
                if (red)       m_fcnt[k] = (m_fcnt[k] >= m_max[k]) ? m_max[k] : m_fcnt[k] + 1;
                if (!m_err[k]) begin
                    if (req && !ack) begin
                        m_consec[k]++;
                        if (m_consec[k] >= m_to[k]) m_err[k] = 1;
                    end else begin
                        m_consec[k] = 0;
                    end
                end
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    task automatic cyc(input bit r, input logic [4:0] s1, input logic [4:0] s2, input bit e1, input bit e2,
                       input logic [4:0] d, input bit l, input bit w, input bit p, input bit q, input bit a);
        @(posedge clk);
        #1;
        rst = r; rs1 = s1; rs2 = s2; u1 = e1; u2 = e2; rd = d; ld = l; wr = w; pcs = p; req = q; ack = a;
        @(negedge clk);
        cycle++;
        compare();
    endtask

    task automatic idle();      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();  cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lu5();       cyc(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0); endtask
    task automatic miss(input bit p); cyc(0, 0, 0, 0, 0, 0, 0, 0, p, 1, 0); endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; ld = 0; wr = 0; pcs = 0; req = 0; ack = 0;
        do_reset();
        idle();
        chk("lit_reset_stall_cnt", {32'd0, a_scnt}, 0);
        chk("lit_reset_err", {63'd0, a_err}, 0);

        lu5();
        chk("lit_lu_pc_en", {63'd0, a_pc_en}, 0);
        chk("lit_lu_stall_if_id", {63'd0, a_st_ifid}, 1);
        chk("lit_lu_flush_id_ex", {63'd0, a_fl_idex}, 1);
        idle();
        chk("lit_lu_stall_cnt", {32'd0, a_scnt}, 1);
        chk("lit_lu_after_pc_en", {63'd0, a_pc_en}, 1);

        cyc(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        chk("lit_x0_stall_if_id", {63'd0, a_st_ifid}, 0);
        chk("lit_x0_pc_en", {63'd0, a_pc_en}, 1);

        cyc(0, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        chk("lit_redir_flush_if_id", {63'd0, a_fl_ifid}, 1);
        chk("lit_redir_flush_id_ex", {63'd0, a_fl_idex}, 1);
        chk("lit_redir_pc_en", {63'd0, a_pc_en}, 1);
        chk("lit_redir_stall_if_id", {63'd0, a_st_ifid}, 0);
        idle();
        chk("lit_redir_flush_cnt", {32'd0, a_fcnt}, 1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            miss(1);
            chk("lit_wait_flush_if_id", {63'd0, a_fl_ifid}, 0);
            chk("lit_wait_pc_en", {63'd0, a_pc_en}, 0);
            chk("lit_wait_stall_ex_mem", {63'd0, a_st_exmem}, 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("lit_ack_flush_if_id", {63'd0, a_fl_ifid}, 1);
        chk("lit_ack_pc_en", {63'd0, a_pc_en}, 1);
        idle();
        chk("lit_wait_stall_cnt", {32'd0, a_scnt}, 3);
        chk("lit_wait_flush_cnt", {32'd0, a_fcnt}, 1);

        do_reset();
        for (int i = 0; i < 4; i++) miss(0);
        idle();
        chk("lit_to_b_err", {63'd0, b_err}, 1);
        chk("lit_to_b_pc_en", {63'd0, b_pc_en}, 0);
        chk("lit_to_b_stall_ex_mem", {63'd0, b_st_exmem}, 1);
        chk("lit_to_a_err", {63'd0, a_err}, 0);
        do_reset();
        idle();
        chk("lit_to_clr_b_err", {63'd0, b_err}, 0);
        chk("lit_to_clr_b_pc_en", {63'd0, b_pc_en}, 1);

        miss(0);
        miss(0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("lit_midreset_stall_cnt", {32'd0, a_scnt}, 0);
        chk("lit_midreset_b_err", {63'd0, b_err}, 0);
        chk("lit_midreset_pc_en", {63'd0, a_pc_en}, 1);

        do_reset();
        for (int i = 0; i < 20; i++) lu5();
        idle();
        chk("lit_sat_b_stall_cnt", {60'd0, b_scnt}, 15);
        chk("lit_sat_a_stall_cnt", {32'd0, a_scnt}, 20);

        do_reset();
        for (int i = 0; i < 254; i++) miss(0);
        miss(0);
        chk("lit_a_to_err_before", {63'd0, a_err}, 0);
        idle();
        chk("lit_a_to_err_after", {63'd0, a_err}, 1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 64) == 0,
                5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 1'($urandom),
                5'($urandom % 4), ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                ($urandom % 3) == 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
